// File: rtl/z_sel_pkg.sv
// z_sel_pkg: shared types and limits for the z select driver.
//   z_sel_state_t  : which consumer path is currently selected
//   Z_SEL_MAX_HOLD : largest legal dwell time in cycles
//   z_of_state     : decode from FSM state to the z select bit
package z_sel_pkg;

    typedef enum logic {SEL_B = 1'b0, SEL_A = 1'b1} z_sel_state_t;

    localparam int unsigned Z_SEL_MAX_HOLD = 32'd255;

    // z=1 selects path A, z=0 selects path B
    function automatic logic z_of_state(input z_sel_state_t state);
        return (state == SEL_A) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/z_sel_driver_chk.sv
// z_sel_driver_chk: run-time invariant checks on the z select driver outputs.
//   i_clk, i_rst : clock and synchronous active-high reset of the driver
//   i_z          : select bit as driven to the consumer
//   i_switch     : switch pulse
//   i_hold_busy  : dwell-in-progress flag
module z_sel_driver_chk
    import z_sel_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 32'd4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_z,
    input  logic i_switch,
    input  logic i_hold_busy
);

    logic z_prev_q;
    logic z_prev_d;
    logic idle_prev_q;
    logic idle_prev_d;

    // Snapshot of last cycle's z and whether a switch was allowed then
    always_comb begin
        z_prev_d    = i_z;
        idle_prev_d = !i_hold_busy;
    end

    // History registers; reset matches the driver's reset state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            z_prev_q    <= 1'b0;
            idle_prev_q <= 1'b1;
        end else begin
            z_prev_q    <= z_prev_d;
            idle_prev_q <= idle_prev_d;
        end
    end

    // Invariants: z never unknown, a switch always starts a dwell,
    // and z only moves when the previous cycle had no dwell pending
    always_comb begin
        if (!i_rst) begin
            assert final ((^i_z) !== 1'bx)
                else $error("z_sel_driver: o_z is unknown");
            if (HOLD_CYCLES > 32'd1) begin
                assert final (!i_switch || i_hold_busy)
                    else $error("z_sel_driver: o_switch without o_hold_busy");
            end else begin
            end
            assert final ((i_z == z_prev_q) || idle_prev_q)
                else $error("z_sel_driver: o_z changed during dwell");
        end else begin
        end
    end

endmodule

// File: rtl/z_sel_driver_dwell_timer.sv
// dwell_timer: minimum-dwell down counter.
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset, clears the count
//   i_load : load LOAD this cycle (takes priority over the decrement)
//   o_busy : registered, 1 while the count is nonzero
// The count saturates at zero; a LOAD of zero gives a timer that is never busy.
module dwell_timer #(
    parameter int unsigned WIDTH = 32'd3,
    parameter int unsigned LOAD  = 32'd3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_busy
);

    localparam logic [WIDTH-1:0] LOAD_V = WIDTH'(LOAD);
    localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(0);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             busy_q;
    logic             busy_d;

    // Next count: load on a switch, else count down and stick at zero
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = LOAD_V;
        end else if (cnt_q != ZERO_V) begin
            cnt_d = cnt_q - ONE_V;
        end else begin
            cnt_d = ZERO_V;
        end
        busy_d = (cnt_d != ZERO_V);
    end

    // Count register and registered busy flag
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= ZERO_V;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/z_sel_driver.sv
// z_sel_driver: producer of the select bit z for a two-input consumer mux.
// Round-robin between a request for path A (z=1) and path B (z=0), with a
// minimum dwell of HOLD_CYCLES cycles after every change.
//   i_clk       : clock, rising edge
//   i_rst       : synchronous active-high reset -> path B, no dwell
//   i_req_a     : level request for path A
//   i_req_b     : level request for path B
//   i_lock      : freeze the current selection while high
//   o_z         : registered select bit
//   o_switch    : 1-cycle pulse in the first cycle o_z shows a new value
//   o_hold_busy : 1 while the dwell has not yet expired
module z_sel_driver
    import z_sel_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 32'd4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_lock,
    output logic o_z,
    output logic o_switch,
    output logic o_hold_busy
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 32'd1);

    if ((HOLD_CYCLES < 32'd1) || (HOLD_CYCLES > Z_SEL_MAX_HOLD)) begin : g_bad_hold
        $fatal(1, "z_sel_driver: HOLD_CYCLES must be in 1..255");
    end

    z_sel_state_t state_q;
    z_sel_state_t state_d;
    logic         z_q;
    logic         z_d;
    logic         switch_q;
    logic         switch_d;
    logic         want_s;
    logic         busy_s;

    // Switch decision: only the non-selected request matters. With both
    // requests high this still switches, which is the round-robin hand-over.
    always_comb begin
        state_d  = state_q;
        want_s   = 1'b0;
        switch_d = 1'b0;
        case (state_q)
            SEL_A:   want_s = i_req_b;
            SEL_B:   want_s = i_req_a;
            default: want_s = 1'b0;
        endcase
        if (!busy_s && !i_lock && want_s) begin
            switch_d = 1'b1;
            state_d  = (state_q == SEL_A) ? SEL_B : SEL_A;
        end else begin
            switch_d = 1'b0;
            state_d  = state_q;
        end
        z_d = z_of_state(state_d);
    end

    // FSM state with registered z and switch pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= SEL_B;
            z_q      <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            z_q      <= z_d;
            switch_q <= switch_d;
        end
    end

    dwell_timer #(
        .WIDTH (CNT_W),
        .LOAD  (HOLD_CYCLES - 32'd1)
    ) u_dwell (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (switch_d),
        .o_busy (busy_s)
    );

    z_sel_driver_chk #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_chk (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_z         (z_q),
        .i_switch    (switch_q),
        .i_hold_busy (busy_s)
    );

    assign o_z         = z_q;
    assign o_switch    = switch_q;
    assign o_hold_busy = busy_s;

endmodule

// File: tb/tb_z_sel_driver.sv
// Bench for z_sel_driver: two instances (dwell 4 and dwell 1) share the
// same stimulus and are compared each cycle against a cycle-level model
// that tracks the selected path and the number of cycles left in the dwell.
module tb_z_sel_driver;

    logic clk = 1'b0;
    logic rst;
    logic req_a;
    logic req_b;
    logic lock;
    logic z4, sw4, hb4;
    logic z1, sw1, hb1;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: 0 = dwell 4, 1 = dwell 1
    int hold_m [2] = '{4, 1};
    int mz     [2];
    int mleft  [2];
    int msw    [2];

    always #5 clk = ~clk;

    z_sel_driver #(.HOLD_CYCLES(32'd4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_req_a(req_a), .i_req_b(req_b),
        .i_lock(lock), .o_z(z4), .o_switch(sw4), .o_hold_busy(hb4)
    );

    z_sel_driver #(.HOLD_CYCLES(32'd1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req_a(req_a), .i_req_b(req_b),
        .i_lock(lock), .o_z(z1), .o_switch(sw1), .o_hold_busy(hb1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mz[k] = 0; mleft[k] = 0; msw[k] = 0;
            end else begin
                int other_wanted;
                other_wanted = (mz[k] == 1) ? int'(req_b) : int'(req_a);
                if (mleft[k] == 0 && !lock && other_wanted == 1) begin
                    mz[k]    = 1 - mz[k];
                    mleft[k] = hold_m[k] - 1;
                    msw[k]   = 1;
                end else begin
                    mleft[k] = (mleft[k] > 0) ? mleft[k] - 1 : 0;
                    msw[k]   = 0;
                end
            end
        end
    endtask

    // Check outputs mid-cycle, then apply the inputs for the next edge
    task automatic step(input logic r, input logic a, input logic b, input logic l);
        @(negedge clk);
        check_eq("z_h4",     {31'b0, z4},  mz[0]);
        check_eq("sw_h4",    {31'b0, sw4}, msw[0]);
        check_eq("busy_h4",  {31'b0, hb4}, (mleft[0] != 0) ? 1 : 0);
        check_eq("z_h1",     {31'b0, z1},  mz[1]);
        check_eq("sw_h1",    {31'b0, sw1}, msw[1]);
        check_eq("busy_h1",  {31'b0, hb1}, (mleft[1] != 0) ? 1 : 0);
        rst = r; req_a = a; req_b = b; lock = l;
        model_step();
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; lock = 1'b0;
        model_step();

        // Reset held two cycles, then idle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Single request for A: one switch, dwell, then stable
        repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);

        // Both requests: alternate every dwell period
        repeat (16) step(1'b0, 1'b1, 1'b1, 1'b0);

        // Request for B pulsed during dwell is dropped, held one is taken
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Lock freezes A while B is requested, release lets it switch
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-dwell, then an immediate switch back to A
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b1, 1'b0);

        // Random traffic with occasional lock and reset
        repeat (600) begin
            step(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                 1'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
